// File: rtl/control_sequencer_pkg.sv
// control_pkg: shared types, field positions and constants for control_sequencer.
//   state_t      FETCH/EXEC/HALT state encoding
//   ir_width     instruction width from field widths, layout {bit7, dest, bit3, source}
//   *_pos/dst_lo bit positions of the instruction fields
//   cond_vec     jump condition vector indexed by {bit7, bit3}
package control_pkg;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  localparam int DST_IR = 0;
  localparam int SRC_ROM = 1;
  localparam int HALT_OP = 0;
  localparam int COND_ALWAYS = 0;
  localparam int COND_ZERO = 1;
  localparam int COND_CARRY = 2;
  localparam int COND_SHIFT = 3;
  function automatic int ir_width(int dst_w, int src_w);
    return dst_w + src_w + 2;
  endfunction
  function automatic int bit3_pos(int src_w);
    return src_w;
  endfunction
  function automatic int dst_lo(int src_w);
    return src_w + 1;
  endfunction
  function automatic int bit7_pos(int dst_w, int src_w);
    return dst_w + src_w + 1;
  endfunction
  // flags = {flagShift, flagCarry, aIsZero}
  function automatic logic [3:0] cond_vec(logic [2:0] flags);
    logic [3:0] v;
    v[COND_ALWAYS] = 1'b1;
    v[COND_ZERO] = flags[0];
    v[COND_CARRY] = flags[1];
    v[COND_SHIFT] = flags[2];
    return v;
  endfunction
endpackage

// File: rtl/control_sequencer_onehot_decoder.sv
// onehot_decoder: index to active-low one-hot with enable.
//   i_idx  in  W      selected index
//   i_en   in  1      when 0, output is all ones
//   o_bar  out 2^W    active-low one-hot
module onehot_decoder #(
  parameter int W = 3
) (
  input  logic [W-1:0]    i_idx,
  input  logic            i_en,
  output logic [2**W-1:0] o_bar
);
  always_comb begin
    o_bar = '1;
    if (i_en) o_bar[i_idx] = 1'b0;
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: two-phase FETCH/EXEC/HALT control unit for the nic8 datapath.
//   clk        in   rising-edge clock
//   resetBar   in   synchronous active-low reset
//   romData    in   instruction word, captured in FETCH
//   stepEn     in   advance enable; 0 holds all state and suppresses triggers
//   flags      in   {flagShift, flagCarry, aIsZero}
//   loadBar    out  active-low destination load (0 = IR, last = PC)
//   triggerBar out  loadBar gated with the low clock phase and stepEn
//   assertBar  out  active-low bus source enable
//   doSubtract/doCarryIn/doShiftIn out  ALU mode bits from IR
//   doJump     out  PC loads from bus this EXEC
//   pcInc      out  PC increments at the end of this cycle
//   halted     out  FSM in HALT
//   retired    out  retired instruction count (wraps)
module control_sequencer
  import control_pkg::*;
#(
  parameter int DST_W = 3,
  parameter int SRC_W = 3,
  parameter int CNT_W = 16,
  localparam int IR_W = ir_width(DST_W, SRC_W)
) (
  input  logic                clk,
  input  logic                resetBar,
  input  logic [IR_W-1:0]     romData,
  input  logic                stepEn,
  input  logic [2:0]          flags,
  output logic [2**DST_W-1:0] loadBar,
  output logic [2**DST_W-1:0] triggerBar,
  output logic [2**SRC_W-1:0] assertBar,
  output logic                doSubtract,
  output logic                doCarryIn,
  output logic                doShiftIn,
  output logic                doJump,
  output logic                pcInc,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);
  localparam int B7 = bit7_pos(DST_W, SRC_W);
  localparam int B3 = bit3_pos(SRC_W);
  localparam int DLO = dst_lo(SRC_W);
  state_t r_state, w_next;
  logic [IR_W-1:0] r_ir;
  logic [CNT_W-1:0] r_retired;
  logic [DST_W-1:0] w_dst;
  logic [SRC_W-1:0] w_src;
  logic [2**DST_W-1:0] w_dst_bar;
  logic [3:0] w_cond;
  logic w_b7, w_b3, w_exec, w_halt_op, w_en, w_go;
  assign w_dst = r_ir[DLO +: DST_W];
  assign w_src = r_ir[SRC_W-1:0];
  assign w_b7 = r_ir[B7];
  assign w_b3 = r_ir[B3];
  assign w_exec = r_state == EXEC;
  // HALT is the all-zero word: dest IR with source 0
  assign w_halt_op = (w_dst == DST_W'(DST_IR)) && (r_ir == IR_W'(HALT_OP));
  assign w_en = w_exec && !w_halt_op;
  // reset behaves like a dropped stepEn for the gated outputs, so an aborted EXEC fires nothing
  assign w_go = stepEn && resetBar;
  assign w_cond = cond_vec(flags);
  onehot_decoder #(.W(DST_W)) u_dst (.i_idx(w_dst), .i_en(w_en), .o_bar(w_dst_bar));
  onehot_decoder #(.W(SRC_W)) u_src (.i_idx(w_src), .i_en(w_en), .o_bar(assertBar));
  assign doJump = w_exec && (w_dst == '1) && w_cond[{w_b7, w_b3}];
  // PC load is masked by the jump condition; doJump is 0 for any other dest, keeping that bit high
  assign loadBar = w_dst_bar | {~doJump, {(2**DST_W-1){1'b0}}};
  assign triggerBar = loadBar | {(2**DST_W){clk | ~w_go}};
  assign pcInc = w_go && (r_state == FETCH || (w_en && w_src == SRC_W'(SRC_ROM)));
  assign doSubtract = w_b3;
  assign doShiftIn = w_b3;
  assign doCarryIn = w_b7;
  assign halted = r_state == HALT;
  assign retired = r_retired;
  always_comb begin
    w_next = r_state;
    if (stepEn) w_next = r_state == FETCH ? EXEC : w_exec ? (w_halt_op ? HALT : FETCH) : HALT;
  end
  always_ff @(posedge clk) begin
    if (!resetBar) begin
      r_state <= FETCH;
      r_ir <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (stepEn && r_state == FETCH) r_ir <= romData;
      if (stepEn && w_exec) r_retired <= r_retired + 1'b1;
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scoreboard bench for control_sequencer (CNT_W=2 to exercise wrap).
module tb_control_sequencer;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic resetBar, stepEn;
  logic [7:0] romData;
  logic [2:0] flags;
  logic [7:0] loadBar, triggerBar, assertBar;
  logic doSubtract, doCarryIn, doShiftIn, doJump, pcInc, halted;
  logic [CW-1:0] retired;
  typedef struct {
    string nm;
    logic [7:0] ld, as, tr;
    logic [2:0] pjh;
    logic [CW-1:0] ret;
    logic [2:0] alu;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [7:0] mon_hi;
  int checks = 0, errors = 0, pushed = 0, popped = 0;

  always #5 clk = ~clk;

  control_sequencer #(.DST_W(3), .SRC_W(3), .CNT_W(CW)) dut (
    .clk(clk), .resetBar(resetBar), .romData(romData), .stepEn(stepEn), .flags(flags),
    .loadBar(loadBar), .triggerBar(triggerBar), .assertBar(assertBar),
    .doSubtract(doSubtract), .doCarryIn(doCarryIn), .doShiftIn(doShiftIn),
    .doJump(doJump), .pcInc(pcInc), .halted(halted), .retired(retired)
  );

  task automatic chk(string nm, string f, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", nm, f, act, exp);
    end
  endtask

  // monitor: high-phase trigger snapshot, then full compare in the low phase
  initial forever begin
    @(posedge clk);
    #3 mon_hi = triggerBar;
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      popped++;
      chk(e.nm, "trig_hi", mon_hi, 8'hFF);
      chk(e.nm, "loadBar", loadBar, e.ld);
      chk(e.nm, "assertBar", assertBar, e.as);
      chk(e.nm, "trig_lo", triggerBar, e.tr);
      chk(e.nm, "pc/jmp/hlt", {5'b0, pcInc, doJump, halted}, {5'b0, e.pjh});
      chk(e.nm, "retired", {6'b0, retired}, {6'b0, e.ret});
      if (e.alu[2]) chk(e.nm, "alu", {5'b0, doSubtract, doShiftIn, doCarryIn},
                        {5'b0, e.alu[1], e.alu[1], e.alu[0]});
    end
  end

  // ctl={resetBar,stepEn}; pjh={pcInc,doJump,halted}; alu={valid,sub/shift,carryIn}
  task automatic cyc(string nm, logic [1:0] ctl, logic [7:0] rom, logic [2:0] fl,
                     logic [7:0] ld, logic [7:0] as, logic [7:0] tr, logic [2:0] pjh,
                     logic [CW-1:0] ret, logic [2:0] alu);
    {resetBar, stepEn} = ctl;
    romData = rom;
    flags = fl;
    q.push_back('{nm, ld, as, tr, pjh, ret, alu});
    pushed++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    resetBar = 1'b0; stepEn = 1'b0; romData = 8'h00; flags = 3'b000;
    @(posedge clk);
    #1;
    cyc("rst0", 2'b00, 8'h00, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b000, 2'd0, 3'b000);
    cyc("rst1", 2'b10, 8'h23, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b000, 2'd0, 3'b000);
    cyc("mv_f", 2'b11, 8'h23, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b100, 2'd0, 3'b000);
    cyc("mv_x", 2'b11, 8'hAA, 3'b000, 8'hFB, 8'hF7, 8'hFB, 3'b000, 2'd0, 3'b100);
    cyc("jzt_f", 2'b11, 8'h7B, 3'b001, 8'hFF, 8'hFF, 8'hFF, 3'b100, 2'd1, 3'b000);
    cyc("jzt_x", 2'b11, 8'h00, 3'b001, 8'h7F, 8'hF7, 8'h7F, 3'b010, 2'd1, 3'b110);
    cyc("jzn_f", 2'b11, 8'h7B, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b100, 2'd2, 3'b000);
    cyc("jzn_x0", 2'b10, 8'h00, 3'b000, 8'hFF, 8'hF7, 8'hFF, 3'b000, 2'd2, 3'b110);
    cyc("jzn_x1", 2'b10, 8'h00, 3'b001, 8'h7F, 8'hF7, 8'hFF, 3'b010, 2'd2, 3'b110);
    cyc("jzn_x2", 2'b11, 8'h00, 3'b000, 8'hFF, 8'hF7, 8'hFF, 3'b000, 2'd2, 3'b110);
    cyc("jmp_f", 2'b11, 8'h72, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b100, 2'd3, 3'b000);
    cyc("jmp_x", 2'b11, 8'h00, 3'b000, 8'h7F, 8'hFB, 8'h7F, 3'b010, 2'd3, 3'b100);
    cyc("jc_f", 2'b11, 8'hF0, 3'b010, 8'hFF, 8'hFF, 8'hFF, 3'b100, 2'd0, 3'b000);
    cyc("jc_x", 2'b11, 8'h00, 3'b010, 8'h7F, 8'hFE, 8'h7F, 3'b010, 2'd0, 3'b101);
    cyc("imm_f0", 2'b10, 8'h41, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b000, 2'd1, 3'b000);
    cyc("imm_f", 2'b11, 8'h41, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b100, 2'd1, 3'b000);
    repeat (3)
      cyc("imm_hold", 2'b10, 8'h00, 3'b000, 8'hEF, 8'hFD, 8'hFF, 3'b000, 2'd1, 3'b100);
    cyc("imm_x", 2'b11, 8'h00, 3'b000, 8'hEF, 8'hFD, 8'hEF, 3'b100, 2'd1, 3'b100);
    cyc("rx_f", 2'b11, 8'h23, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b100, 2'd2, 3'b000);
    cyc("rx_x", 2'b01, 8'h00, 3'b000, 8'hFB, 8'hF7, 8'hFF, 3'b000, 2'd2, 3'b100);
    cyc("rx_after", 2'b10, 8'h00, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b000, 2'd0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      cyc("w_f", 2'b11, 8'h23, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b100, CW'(i), 3'b000);
      cyc("w_x", 2'b11, 8'h00, 3'b000, 8'hFB, 8'hF7, 8'hFB, 3'b000, CW'(i), 3'b100);
    end
    cyc("h_f", 2'b11, 8'h00, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b100, 2'd0, 3'b000);
    cyc("h_x", 2'b11, 8'h23, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b000, 2'd0, 3'b100);
    repeat (10)
      cyc("h_hold", 2'b11, 8'h23, 3'b111, 8'hFF, 8'hFF, 8'hFF, 3'b001, 2'd1, 3'b000);
    cyc("h_rst", 2'b01, 8'h23, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b001, 2'd1, 3'b000);
    cyc("h_out", 2'b10, 8'h00, 3'b000, 8'hFF, 8'hFF, 8'hFF, 3'b000, 2'd0, 3'b000);
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0 || popped != pushed) begin
      errors++;
      $display("FAIL drain got popped=%0d want %0d", popped, pushed);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
